// File: rtl/hdmi_slip_ctrl_pkg.sv
// Shared definitions for the HDMI bit-alignment calibration sequencer:
// TMDS control tokens, sequencer state encoding and channel indices.
package hdmi_slip_ctrl_pkg;

  localparam logic [9:0] TMDS_TOK0 = 10'h354;
  localparam logic [9:0] TMDS_TOK1 = 10'h0ab;
  localparam logic [9:0] TMDS_TOK2 = 10'h154;
  localparam logic [9:0] TMDS_TOK3 = 10'h2ab;

  localparam int NUM_CH = 3;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SETTLE  = 4'd1,
    ST_MEASURE = 4'd2,
    ST_DECIDE  = 4'd3,
    ST_LOCKED  = 4'd4,
    ST_FAILED  = 4'd5
  } state_t;

  typedef enum logic [1:0] {
    CH_B = 2'd0,
    CH_G = 2'd1,
    CH_R = 2'd2
  } chan_t;

  function automatic logic is_token(input logic [9:0] w);
    return (w == TMDS_TOK0) || (w == TMDS_TOK1) ||
           (w == TMDS_TOK2) || (w == TMDS_TOK3);
  endfunction

endpackage

// File: rtl/hdmi_token_count.sv
// Per-channel TMDS control-token detector with a saturating window counter.
// o_count_nxt exposes the value including this cycle's word, so a window can
// be judged on its last cycle while the counter restarts for the next one.
module hdmi_token_count
  import hdmi_slip_ctrl_pkg::*;
#(
  parameter int WINDOW_LG = 12
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [9:0]         i_data,
  output logic [WINDOW_LG:0] o_count,
  output logic [WINDOW_LG:0] o_count_nxt
);

  localparam int CW = WINDOW_LG + 1;

  logic [CW-1:0] r_count;
  logic          w_hit;
  logic          w_sat;

  assign w_hit       = i_en && is_token(i_data);
  assign w_sat       = &r_count;
  assign o_count_nxt = (w_hit && !w_sat) ? r_count + CW'(1) : r_count;
  assign o_count     = r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) r_count <= '0;
    else                  r_count <= o_count_nxt;
  end

endmodule

// File: rtl/hdmi_slip_ctrl.sv
// Bitslip calibration sequencer: sweeps B, G, R slips until each channel shows
// enough control tokens per window, then watches for lost alignment.
module hdmi_slip_ctrl
  import hdmi_slip_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int WINDOW_LG     = 12,
  parameter int MIN_TOKENS    = 64,
  parameter int LOSS_WINDOWS  = 4
) (
  input  logic        i_pix_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_recal,
  input  logic [9:0]  i_r,
  input  logic [9:0]  i_g,
  input  logic [9:0]  i_b,
  output logic [4:0]  o_slip_r,
  output logic [4:0]  o_slip_g,
  output logic [4:0]  o_slip_b,
  output logic        o_locked,
  output logic        o_fail,
  output logic [31:0] o_status
);

  localparam int CW = WINDOW_LG + 1;
  localparam int LW = (LOSS_WINDOWS < 3) ? 1 : $clog2(LOSS_WINDOWS);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] WIN_LAST    = CW'((1 << WINDOW_LG) - 1);
  localparam logic [CW-1:0] MIN_T       = CW'(MIN_TOKENS);
  localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_WINDOWS - 1);

  state_t                       r_state;
  chan_t                        r_chan;
  logic [NUM_CH-1:0][4:0]       r_slip;
  logic [CW-1:0]                r_cnt;
  logic [LW-1:0]                r_loss;
  logic                         r_locked;
  logic                         r_fail;

  logic [NUM_CH-1:0][9:0]       w_data;
  logic [NUM_CH-1:0][CW-1:0]    w_count;
  logic [NUM_CH-1:0][CW-1:0]    w_count_nxt;
  logic                         w_en;
  logic                         w_clr;
  logic                         w_win_end;
  logic                         w_pass_cur;
  logic                         w_all_pass;
  logic [4:0]                   w_cur_slip;
  chan_t                        w_next_chan;

  assign w_data = {i_r, i_g, i_b};

  // Counters run in MEASURE and LOCKED only; every other state holds them at
  // zero, so each measurement and each LOCKED window starts from a clean count.
  assign w_en      = (r_state == ST_MEASURE) || (r_state == ST_LOCKED);
  assign w_win_end = (r_cnt == WIN_LAST);
  assign w_clr     = !w_en || ((r_state == ST_LOCKED) && w_win_end);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
    hdmi_token_count #(
      .WINDOW_LG (WINDOW_LG)
    ) u_cnt (
      .i_clk       (i_pix_clk),
      .i_reset     (i_reset),
      .i_clr       (w_clr),
      .i_en        (w_en),
      .i_data      (w_data[gi]),
      .o_count     (w_count[gi]),
      .o_count_nxt (w_count_nxt[gi])
    );
  end

  assign w_cur_slip  = r_slip[r_chan];
  assign w_pass_cur  = (w_count[r_chan] >= MIN_T);
  assign w_next_chan = (r_chan == CH_B) ? CH_G : CH_R;

  always_comb begin
    w_all_pass = 1'b1;
    for (int c = 0; c < NUM_CH; c++)
      if (w_count_nxt[c] < MIN_T) w_all_pass = 1'b0;
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_chan   <= CH_B;
      r_slip   <= '0;
      r_cnt    <= '0;
      r_loss   <= '0;
      r_locked <= 1'b0;
      r_fail   <= 1'b0;
    end else if (!i_enable) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (i_recal) begin
      r_state  <= ST_SETTLE;
      r_chan   <= CH_B;
      r_slip   <= '0;
      r_cnt    <= '0;
      r_loss   <= '0;
      r_locked <= 1'b0;
      r_fail   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_chan       <= CH_B;
          r_slip[CH_B] <= '0;
          r_cnt        <= '0;
          r_state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_MEASURE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_MEASURE: begin
          if (w_win_end) begin
            r_cnt   <= '0;
            r_state <= ST_DECIDE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DECIDE: begin
          r_cnt <= '0;
          if (w_pass_cur) begin
            r_fail <= 1'b0;
            if (r_chan == CH_R) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
              r_loss   <= '0;
            end else begin
              r_chan              <= w_next_chan;
              r_slip[w_next_chan] <= '0;
              r_state             <= ST_SETTLE;
            end
          end else if (w_cur_slip == 5'd9) begin
            r_slip[r_chan] <= '0;
            r_fail         <= 1'b1;
            r_state        <= ST_FAILED;
          end else begin
            r_slip[r_chan] <= w_cur_slip + 5'd1;
            r_state        <= ST_SETTLE;
          end
        end
        ST_LOCKED: begin
          if (w_win_end) begin
            r_cnt <= '0;
            if (w_all_pass) begin
              r_loss <= '0;
            end else if (r_loss == LOSS_LAST) begin
              r_locked <= 1'b0;
              r_loss   <= '0;
              r_chan   <= CH_B;
              r_slip   <= '0;
              r_state  <= ST_SETTLE;
            end else begin
              r_loss <= r_loss + LW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_FAILED: begin
          // Back off one window with slips held before sweeping again.
          if (w_win_end) begin
            r_cnt        <= '0;
            r_chan       <= CH_B;
            r_slip[CH_B] <= '0;
            r_state      <= ST_SETTLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_slip_b = r_slip[CH_B];
  assign o_slip_g = r_slip[CH_G];
  assign o_slip_r = r_slip[CH_R];
  assign o_locked = r_locked;
  assign o_fail   = r_fail;
  assign o_status = {r_locked, r_fail, 2'b00, r_state,
                     3'h0, r_slip[CH_R], 3'h0, r_slip[CH_G], 3'h0, r_slip[CH_B]};

endmodule
